// File: rtl/io_input_port.sv
// io_input_port: switch/button input peripheral for the single-cycle CPU.
// Synchronises raw pins, debounces buttons, latches presses in sticky bits
// and exposes three read-only words plus an ID word on a word-addressed port.
module io_input_port #(
    parameter int NSW       = 16,
    parameter int NBTN      = 5,
    parameter int DB_CYCLES = 1_000_000,
    parameter int DB_BITS   = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSW-1:0]  sw,
    input  logic [NBTN-1:0] btn,
    input  logic            rd_en,
    input  logic [1:0]      addr,
    output logic [31:0]     rdata,
    output logic [NBTN-1:0] btn_event,
    output logic            irq
);

    localparam logic [31:0]        ID_WORD  = 32'h494E_5031;
    localparam logic [DB_BITS-1:0] CNT_LAST = DB_BITS'(DB_CYCLES - 1);
    localparam logic [DB_BITS-1:0] CNT_ONE  = DB_BITS'(32'd1);
    localparam logic [DB_BITS-1:0] CNT_ZERO = DB_BITS'(32'd0);

    // Synchroniser chains (two flops per pin).
    logic [NSW-1:0]  sw_meta_q,  sw_meta_d;
    logic [NSW-1:0]  sw_s_q,     sw_s_d;
    logic [NBTN-1:0] btn_meta_q, btn_meta_d;
    logic [NBTN-1:0] btn_s_q,    btn_s_d;

    // Debounce and event state.
    logic [NBTN-1:0]    stable_q,    stable_d;
    logic [DB_BITS-1:0] cnt_q [NBTN];
    logic [DB_BITS-1:0] cnt_d [NBTN];
    logic [NBTN-1:0]    sticky_q,    sticky_d;
    logic [NBTN-1:0]    btn_event_q, btn_event_d;

    // Per-cycle helpers.
    logic [NBTN-1:0] rise_s;
    logic [NBTN-1:0] clr_s;

    // Next-state: synchronisers, per-button debounce, press detection, sticky set/clear.
    always_comb begin
        sw_meta_d  = sw;
        sw_s_d     = sw_meta_q;
        btn_meta_d = btn;
        btn_s_d    = btn_meta_q;
        stable_d   = stable_q;
        for (int i = 0; i < NBTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (btn_s_q[i] == stable_q[i]) begin
                // Synced level agrees with the accepted level: nothing pending.
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] >= CNT_LAST) begin
                // Level held long enough: accept it and restart for the next change.
                stable_d[i] = btn_s_q[i];
                cnt_d[i]    = CNT_ZERO;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        rise_s = stable_d & ~stable_q;
        // Clear only the bits the CPU is seeing as 1 in this read; a new press wins.
        if (rd_en && (addr == 2'd2)) begin
            clr_s = sticky_q;
        end else begin
            clr_s = {NBTN{1'b0}};
        end
        sticky_d    = (sticky_q & ~clr_s) | rise_s;
        btn_event_d = rise_s;
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q   <= {NSW{1'b0}};
            sw_s_q      <= {NSW{1'b0}};
            btn_meta_q  <= {NBTN{1'b0}};
            btn_s_q     <= {NBTN{1'b0}};
            stable_q    <= {NBTN{1'b0}};
            sticky_q    <= {NBTN{1'b0}};
            btn_event_q <= {NBTN{1'b0}};
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            sw_meta_q   <= sw_meta_d;
            sw_s_q      <= sw_s_d;
            btn_meta_q  <= btn_meta_d;
            btn_s_q     <= btn_s_d;
            stable_q    <= stable_d;
            sticky_q    <= sticky_d;
            btn_event_q <= btn_event_d;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Read mux; while reset is held every state word reads as its zeroed value.
    always_comb begin
        rdata = 32'h0000_0000;
        if (rst) begin
            if (addr == 2'd3) begin
                rdata = ID_WORD;
            end else begin
                rdata = 32'h0000_0000;
            end
        end else begin
            case (addr)
                2'd0:    rdata = 32'(sw_s_q);
                2'd1:    rdata = 32'(stable_q);
                2'd2:    rdata = 32'(sticky_q);
                2'd3:    rdata = ID_WORD;
                default: rdata = 32'h0000_0000;
            endcase
        end
    end

    // Event pulse and interrupt, forced low while reset is held.
    always_comb begin
        if (rst) begin
            btn_event = {NBTN{1'b0}};
            irq       = 1'b0;
        end else begin
            btn_event = btn_event_q;
            irq       = |sticky_q;
        end
    end

endmodule
